cordic_iterative: RTL and testbench
===================================

CORDIC_ITERATIVE -- requirements
Module: cordic_iterative

Interface
REQ-001 SHALL have parameter Width, default 16, signed data/angle word width, fixed point Q2.(Width-2).
REQ-002 SHALL have parameter Iterations, default 16, number of micro-rotations, legal range 1..16.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-006 SHALL have ports x_i, y_i, z_i  input  Width each  initial vector (x,y) and angle z in radians.
REQ-007 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done_o  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have ports x_o, y_o, z_o  output  Width each  rotated vector and residual angle.

Function
REQ-010 SHALL implement the FSM IDLE -> ROTATE -> [SCALE] -> DONE -> IDLE; SCALE exists only per REQ-026.
REQ-011 In IDLE, start_i=1 SHALL load x_i/y_i/z_i into the working registers, clear the 4-bit iteration counter i, and enter ROTATE on the same edge.
REQ-012 Each ROTATE edge SHALL apply d=+1 if z>=0 else -1: x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*atan_lut[i], then i=i+1.
REQ-013 Shifts SHALL be arithmetic (sign-fill), produced by two instances of the existing barrel_shifter block with amount_i driven by i.
REQ-014 atan_lut SHALL be a constant Q2.14 table, i=0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.
REQ-015 Adders SHALL be Width bits, two's-complement wrap, no saturation; inputs with |x|,|y|>0.6 of full scale are out of contract.
REQ-016 After the iteration with i=Iterations-1, FSM SHALL leave ROTATE, so ROTATE lasts exactly Iterations edges.
REQ-017 On entering DONE, x_o/y_o/z_o SHALL be updated from the working registers and done_o SHALL be 1 for exactly that one cycle.
REQ-018 Latency without SCALE SHALL be: start sampled at edge 0, done_o high in the cycle following edge Iterations+1.
REQ-019 x_o/y_o/z_o SHALL hold their value until the next DONE; they do not change during ROTATE.
REQ-020 start_i SHALL be ignored in ROTATE, SCALE and DONE, with no queuing; back-to-back operation therefore needs start_i in the cycle after done_o.
REQ-021 Without gain compensation, outputs SHALL carry the CORDIC gain K~1.64676 (Iterations=16).

Reset
REQ-022 rst_i=1 at an edge SHALL force IDLE, i=0, working registers=0, x_o=y_o=z_o=0, busy_o=0, done_o=0.
REQ-023 rst_i SHALL take priority over start_i on the same edge.
REQ-024 Reset during ROTATE or SCALE SHALL abort the operation with no done_o pulse, and SHALL clear the previous outputs.
REQ-025 After reset is released, the first start_i in IDLE SHALL begin a normal operation.

Configuration
REQ-026 Macro CORDIC_GAIN_COMP_EN defined: a SCALE state of one edge SHALL follow ROTATE.
REQ-027 In SCALE, x and y SHALL be multiplied by 9949 (1/K in Q2.14), arithmetic-shifted right by 14 (truncating), then DONE is entered; latency is Iterations+2.
REQ-028 Macro CORDIC_GAIN_COMP_EN undefined: no SCALE state and no multiplier SHALL exist; latency is per REQ-018.

Verification
REQ-029 Without macro: x_i=9949, y_i=0, z_i=0, start -> done_o in the cycle after edge 17; x_o=16384+/-8, y_o=0+/-8, z_o within +/-2.
REQ-030 Without macro: x_i=9949, y_i=0, z_i=12868 (pi/4) -> x_o=y_o=11585+/-8; with z_i=-12868 -> x_o=11585+/-8, y_o=-11585+/-8.
REQ-031 With macro: x_i=16384, y_i=0, z_i=25736 (pi/2) -> done_o after edge 18; x_o=0+/-8, y_o=16384+/-8.
REQ-032 start_i held high for 40 cycles -> operations are accepted only in IDLE; done_o pulses are one cycle each, spaced Iterations+2 cycles apart (no macro).
REQ-033 rst_i asserted at edge 5 of an operation -> no done_o; all outputs 0 on the next cycle; busy_o=0; a following start completes normally.
REQ-034 Iterations=1, z_i=100 -> done_o after edge 2; x_o=x_i-(y_i), y_o=y_i+x_i, z_o=100-12868.

Source files
------------

// File: rtl/cordic_iterative.sv
// Iterative CORDIC rotator: one micro-rotation per clock.
// Optional macro CORDIC_GAIN_COMP_EN adds a SCALE step removing the gain.

module barrel_shifter #(
  parameter int Width = 16
) (
  input  logic [Width-1:0] data_i,
  input  logic [3:0]       amount_i,
  output logic [Width-1:0] data_o
);
  logic [Width-1:0] s0, s1, s2;
  logic             sg;

  assign sg = data_i[Width-1];
  assign s0 = amount_i[0] ?
    {sg, data_i[Width-1:1]} : data_i;
  assign s1 = amount_i[1] ?
    {{2{sg}}, s0[Width-1:2]} : s0;
  assign s2 = amount_i[2] ?
    {{4{sg}}, s1[Width-1:4]} : s1;
  assign data_o = amount_i[3] ?
    {{8{sg}}, s2[Width-1:8]} : s2;
endmodule

module cordic_iterative #(
  parameter int Width      = 16,
  parameter int Iterations = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [Width-1:0] z_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic [Width-1:0] z_o
);
`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {
    IDLE, ROTATE, SCALE, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, ROTATE, DONE
  } state_t;
`endif

  localparam logic [3:0] Last = 4'(Iterations - 1);

  state_t                  state;
  logic [3:0]              i;
  logic signed [Width-1:0] x, y, z;
  logic signed [Width-1:0] xs, ys, atan;
  logic [47:0]             aw;

  barrel_shifter #(.Width(Width)) u_shx (
    .data_i  (x),
    .amount_i(i),
    .data_o  (xs)
  );

  barrel_shifter #(.Width(Width)) u_shy (
    .data_i  (y),
    .amount_i(i),
    .data_o  (ys)
  );

  function automatic logic [15:0] atan_q14(
    input logic [3:0] k
  );
    logic [15:0] v;
    unique case (k)
      4'd0:  v = 16'd12868;
      4'd1:  v = 16'd7596;
      4'd2:  v = 16'd4014;
      4'd3:  v = 16'd2037;
      4'd4:  v = 16'd1023;
      4'd5:  v = 16'd512;
      4'd6:  v = 16'd256;
      4'd7:  v = 16'd128;
      4'd8:  v = 16'd64;
      4'd9:  v = 16'd32;
      4'd10: v = 16'd16;
      4'd11: v = 16'd8;
      4'd12: v = 16'd4;
      4'd13: v = 16'd2;
      4'd14: v = 16'd1;
      4'd15: v = 16'd0;
    endcase
    return v;
  endfunction

  // table is Q2.14; rescale to the Q2.(Width-2) word
  assign aw   = 48'(atan_q14(i));
  assign atan = Width'((aw << Width) >> 16);

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [Width+15:0] px, py;
  assign px = (Width+16)'(x) * (Width+16)'(16'sd9949);
  assign py = (Width+16)'(y) * (Width+16)'(16'sd9949);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      i      <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      x_o    <= '0;
      y_o    <= '0;
      z_o    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            x      <= x_i;
            y      <= y_i;
            z      <= z_i;
            i      <= '0;
            busy_o <= 1'b1;
            state  <= ROTATE;
          end
        end
        ROTATE: begin
          if (z[Width-1]) begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan;
          end else begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan;
          end
          i <= i + 4'd1;
          if (i == Last) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= SCALE;
`else
            state <= DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          x     <= Width'(px >>> 14);
          y     <= Width'(py >>> 14);
          state <= DONE;
        end
`endif
        DONE: begin
          x_o    <= x;
          y_o    <= y;
          z_o    <= z;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iterative.sv
// Bench for cordic_iterative: cycle-level reference model plus directed
// and random operations. Honors CORDIC_GAIN_COMP_EN when defined.

module tb_cordic_iterative;
  localparam int N = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int Lat  = N + 2;
  localparam int Lat1 = 3;
`else
  localparam int Lat  = N + 1;
  localparam int Lat1 = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic [15:0] xi, yi, zi, x1, y1, z1;
  logic        busy, done, busy1, done1;
  logic [15:0] xo, yo, zo, xo1, yo1, zo1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_iterative #(.Width(16), .Iterations(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .x_i(xi), .y_i(yi), .z_i(zi),
    .busy_o(busy), .done_o(done),
    .x_o(xo), .y_o(yo), .z_o(zo)
  );

  cordic_iterative #(.Width(16), .Iterations(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .x_i(x1), .y_i(y1), .z_i(z1),
    .busy_o(busy1), .done_o(done1),
    .x_o(xo1), .y_o(yo1), .z_o(zo1)
  );

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic near(input string nm, input int act,
                      input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d+/-%0d",
               nm, act, exp, tol);
    end
  endtask

  function automatic logic signed [15:0] atan_ref(input int k);
    case (k)
      0: return 16'sd12868;  1: return 16'sd7596;
      2: return 16'sd4014;   3: return 16'sd2037;
      4: return 16'sd1023;   5: return 16'sd512;
      6: return 16'sd256;    7: return 16'sd128;
      8: return 16'sd64;     9: return 16'sd32;
      10: return 16'sd16;    11: return 16'sd8;
      12: return 16'sd4;     13: return 16'sd2;
      14: return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  // whole-operation result, Q2.14 with 16-bit wrap
  function automatic void cordic_ref(
    input int n,
    input logic signed [15:0] xa, ya, za,
    output logic signed [15:0] xr, yr, zr);
    logic signed [15:0] sx, sy;
    xr = xa; yr = ya; zr = za;
    for (int k = 0; k < n; k++) begin
      sx = xr >>> k;
      sy = yr >>> k;
      if (zr >= 0) begin
        xr = xr - sy; yr = yr + sx; zr = zr - atan_ref(k);
      end else begin
        xr = xr + sy; yr = yr - sx; zr = zr + atan_ref(k);
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    xr = 16'((int'(xr) * 9949) >>> 14);
    yr = 16'((int'(yr) * 9949) >>> 14);
`endif
  endfunction

  // transaction-level model: countdown to the done cycle
  int                 cnt = 0;
  logic               mvalid = 1'b0;
  logic               edone = 1'b0, ebusy = 1'b0;
  logic signed [15:0] px, py, pz;
  logic signed [15:0] ex = 0, ey = 0, ez = 0;

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; edone = 1'b0;
      ex = 0; ey = 0; ez = 0;
      mvalid = 1'b1;
    end else begin
      edone = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          edone = 1'b1;
          ex = px; ey = py; ez = pz;
        end
      end else if (start) begin
        cnt = Lat;
        cordic_ref(N, xi, yi, zi, px, py, pz);
      end
    end
    ebusy = (cnt > 0);
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("done_o", int'(done), int'(edone));
      check("busy_o", int'(busy), int'(ebusy));
      check("x_o", int'($signed(xo)), int'(ex));
      check("y_o", int'($signed(yo)), int'(ey));
      check("z_o", int'($signed(zo)), int'(ez));
    end
  end

  task automatic run_op(input logic [15:0] a, b, c);
    int lat;
    xi = a; yi = b; zi = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, Lat);
  endtask

  logic signed [15:0] ax, ay, az;
  int r, np, first, second, lat1, nd;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    xi = '0; yi = '0; zi = '0;
    x1 = '0; y1 = '0; z1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(xo), 0);
    rst = 1'b0;

    cordic_ref(1, 16'sd1000, 16'sd500, 16'sd100, ax, ay, az);
`ifdef CORDIC_GAIN_COMP_EN
    check("pin1_x", int'(ax), 303);
    check("pin1_y", int'(ay), 910);
`else
    check("pin1_x", int'(ax), 500);
    check("pin1_y", int'(ay), 1500);
`endif
    check("pin1_z", int'(az), -12768);

`ifdef CORDIC_GAIN_COMP_EN
    run_op(16'd16384, 16'd0, 16'd25736);
    near("pi2_x", int'($signed(xo)), 0, 8);
    near("pi2_y", int'($signed(yo)), 16384, 8);
`else
    run_op(16'd9949, 16'd0, 16'd0);
    near("z0_x", int'($signed(xo)), 16384, 8);
    near("z0_y", int'($signed(yo)), 0, 8);
    near("z0_z", int'($signed(zo)), 0, 2);
    run_op(16'd9949, 16'd0, 16'd12868);
    near("p4_x", int'($signed(xo)), 11585, 8);
    near("p4_y", int'($signed(yo)), 11585, 8);
    run_op(16'd9949, 16'd0, 16'(-12868));
    near("m4_x", int'($signed(xo)), 11585, 8);
    near("m4_y", int'($signed(yo)), -11585, 8);
`endif

    repeat (25) begin
      r = int'($urandom_range(0, 26000)) - 13000;
      xi = 16'(r);
      r = int'($urandom_range(0, 26000)) - 13000;
      run_op(xi, 16'(r), 16'($urandom));
    end

    // start held high: accepted only when idle
    xi = 16'd7000; yi = 16'd3000; zi = 16'd5000;
    start = 1'b1;
    np = 0; first = 0; second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        np++;
        if (np == 1) first = c;
        if (np == 2) second = c;
      end
    end
    start = 1'b0;
    check("held_pulses", np, 2);
    check("held_spacing", second - first, Lat + 1);
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    check("held_drain", int'(busy), 0);

    // reset sampled at edge 5 of an operation
    xi = 16'd8000; yi = 16'd1000; zi = 16'd3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_x", int'(xo), 0);
    check("abort_y", int'(yo), 0);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_nodone", nd, 0);
    run_op(16'd6000, 16'd2000, 16'd4000);

    // single-iteration instance
    x1 = 16'd1000; y1 = 16'd500; z1 = 16'd100;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done1) begin
        lat1 = k;
        break;
      end
    end
    check("it1_latency", lat1, Lat1);
`ifdef CORDIC_GAIN_COMP_EN
    check("it1_x", int'($signed(xo1)), 303);
    check("it1_y", int'($signed(yo1)), 910);
`else
    check("it1_x", int'($signed(xo1)), 500);
    check("it1_y", int'($signed(yo1)), 1500);
`endif
    check("it1_z", int'($signed(zo1)), -12768);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
